// File: rtl/vfp_pixel_tracker.sv
// Re-registers a raw RGB pixel stream and tags each pixel with x/y coordinates,
// line/frame pulses, a completed-frame count and a sticky sim_done flag.
module vfp_pixel_tracker #(
   parameter int IMG_WIDTH  = 400,
   parameter int IMG_HEIGHT = 300,
   parameter int FRAMES_CNT = 1,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_red,
   input  logic [DATA_WIDTH-1:0] i_green,
   input  logic [DATA_WIDTH-1:0] i_blue,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_red,
   output logic [DATA_WIDTH-1:0] o_green,
   output logic [DATA_WIDTH-1:0] o_blue,
   output logic [15:0]           o_x_coord,
   output logic [15:0]           o_y_coord,
   output logic                  o_increment_row,
   output logic                  o_frame_done,
   output logic [15:0]           o_frame_count,
   output logic                  o_sim_done,
   output logic [1:0]            o_dbg_state
);

   // Stream handshake: no back-pressure. A pixel is taken on any edge where
   // i_valid=1 and the tracker is not DONE; it shows up on o_* one edge later
   // with o_valid=1. o_valid=0 marks a cycle whose outputs carry no new pixel.

   localparam logic [15:0] X_LAST     = 16'(IMG_WIDTH - 1);
   localparam logic [15:0] Y_LAST     = 16'(IMG_HEIGHT - 1);
   localparam logic [15:0] FRAMES_TGT = 16'(FRAMES_CNT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [15:0]           x_q, x_d, y_q, y_d;
   logic [15:0]           cnt_q, cnt_d, cnt_inc;
   logic                  sd_q, sd_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic [15:0]           ox_q, ox_d, oy_q, oy_d;
   logic                  inc_q, inc_d, fd_q, fd_d;
   logic                  accept, last_col, last_pix;

   assign accept   = i_valid && (state_q != ST_DONE);
   assign last_col = (x_q == X_LAST);
   assign last_pix = last_col && (y_q == Y_LAST);
   // Frame count saturates rather than wrapping.
   assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      sd_d    = sd_q;
      valid_d = 1'b0;
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      inc_d   = 1'b0;
      fd_d    = 1'b0;
      if (accept) begin
         valid_d = 1'b1;
         red_d   = i_red;
         green_d = i_green;
         blue_d  = i_blue;
         ox_d    = x_q;
         oy_d    = y_q;
         inc_d   = last_col;
         fd_d    = last_pix;
         state_d = ST_ACTIVE;
         x_d     = last_col ? 16'd0 : x_q + 16'd1;
         if (last_col) begin
            y_d = last_pix ? 16'd0 : y_q + 16'd1;
         end
         if (last_pix) begin
            cnt_d = cnt_inc;
            // The frame that reaches the target count ends the run.
            if (cnt_inc == FRAMES_TGT) begin
               sd_d    = 1'b1;
               state_d = ST_DONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         sd_q    <= 1'b0;
         valid_q <= 1'b0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         inc_q   <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         sd_q    <= sd_d;
         valid_q <= valid_d;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         inc_q   <= inc_d;
         fd_q    <= fd_d;
      end
   end

   assign o_valid         = valid_q;
   assign o_red           = red_q;
   assign o_green         = green_q;
   assign o_blue          = blue_q;
   assign o_x_coord       = ox_q;
   assign o_y_coord       = oy_q;
   assign o_increment_row = inc_q;
   assign o_frame_done    = fd_q;
   assign o_frame_count   = cnt_q;
   assign o_sim_done      = sd_q;
   assign o_dbg_state     = state_q;

endmodule
